serial_slt_unit: RTL and testbench
==================================

Name: serial_slt_unit

Overview:
- Multi-cycle set-less-than/compare unit for the ALU SLT/SLTU path.
- Latches two operands on a start handshake and walks them MSB-first, one bit per cycle, through a one_bit_comparator cell.
- Feeds the cell's gin/ein inputs from registered state and consumes its gout/eout outputs.
- Produces registered lt/eq/gt flags with a one-cycle done pulse.
- Terminates early on the first differing bit.

Parameters:
- WIDTH, 32, operand width in bits (>=2).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- start  input  1  request; accepted only in IDLE.
- a  input  WIDTH  operand A; sampled on accepted start.
- b  input  WIDTH  operand B; sampled on accepted start.
- is_signed  input  1  1 = two's-complement compare (SLT), 0 = unsigned (SLTU); sampled on accepted start.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse; result valid.
- lt  output  1  A < B.
- eq  output  1  A == B.
- gt  output  1  A > B.

Behaviour:
- Reset is synchronous and active-high, on clk. When rst=1 at a clock edge:
  - state goes to IDLE.
  - busy, done, lt, eq, gt are all 0.
  - internal g=0, e=1, idx=WIDTH-1.
- Reset mid-operation aborts the operation: no done pulse, results cleared.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at edge T is accepted.
  - Latch a_r=a, b_r=b.
  - If is_signed=1, store the MSB of each operand inverted (bias trick), so the unsigned bit walk gives the signed order.
  - g<=0, e<=1, idx<=WIDTH-1.
  - lt/eq/gt cleared to 0.
  - Next state is RUN.
- RUN, each cycle:
  - The comparator cell sees gin=g, ein=e, xin=a_r[idx], yin=b_r[idx].
  - Update g<=gout, e<=eout, idx<=idx-1.
  - If eout=0 or idx==0: next state is DONE, and lt<=~gout&~eout, eq<=eout, gt<=gout.
- DONE: done=1 for exactly one cycle, then back to IDLE.
- lt/eq/gt hold their value in IDLE until the next accepted start.
- Exactly one of lt/eq/gt is 1 after any completed operation.
- Latency, with start accepted at edge T:
  - RUN cycle k (k=1..) processes bit WIDTH-k at edge T+k.
  - First difference at bit i: done is high in the cycle after edge T+(WIDTH-i)+1.
  - Equal operands: full latency WIDTH+1 (done after edge T+WIDTH+1).
  - Minimum latency (MSBs differ): 2.
- start while busy=1 (RUN or DONE) is ignored; operands are not re-sampled.
- Back-to-back operation: start in the first IDLE cycle after done is accepted. No start is accepted in the done cycle itself.
- idx is $clog2(WIDTH) bits wide and never wraps: the walk exits at idx==0 before decrementing below 0.
- Inputs a, b, is_signed are don't-care except at the accepted start edge.

Decomposition:
- Shared package alu_cmp_pkg holds:
  - state enum ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
  - CMP_LT/CMP_EQ/CMP_GT result index constants, shared with the ALU result mux.
- One sub-module: one instance of the existing one_bit_comparator cell as the per-cycle datapath.
- The FSM, the operand registers, and the MSB-bias logic stay in serial_slt_unit.

Test Plan:
- Unsigned, small values: a=5, b=9, is_signed=0, start at T -> lt=1, eq=0, gt=0; done exactly one cycle, after edge T+30 (first difference at bit 3).
- Sign handling, same operands both ways:
  - a=32'hFFFFFFFF, b=1, is_signed=1 -> lt=1, done after T+2.
  - Same operands with is_signed=0 -> gt=1, done after T+2.
- Equal operands: a=b=32'hDEADBEEF, either sign mode -> eq=1, lt=gt=0; done after T+33; busy high for 33 cycles.
- Ignored start plus back-to-back:
  - a=32'h80000000, b=32'h7FFFFFFF, is_signed=1 -> lt=1.
  - Second start with a=3, b=3 at T+1 (busy) is ignored; result still lt=1.
  - A start in the first IDLE cycle after done is accepted and yields eq=1.
- Reset mid-operation: equal operands, rst=1 at T+10 for one cycle -> busy=0, done never pulses, lt=eq=gt=0. A following start with a=0, b=1 (unsigned) gives lt=1 after bit 0 (done after T'+33).
- Width corner: WIDTH=2, a=2'b10, b=2'b01, is_signed=1 -> lt=1 after T+2; same operands with is_signed=0 -> gt=1.

Source files
------------

// File: rtl/alu_cmp_pkg.sv
// Shared definitions for the serial compare path: FSM encodings and the
// result-flag indices also used by the ALU result mux.
package alu_cmp_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int CMP_LT = 0;
    localparam int CMP_EQ = 1;
    localparam int CMP_GT = 2;

endpackage

// File: rtl/one_bit_comparator.sv
// Cascadable magnitude-compare cell: folds one bit pair (MSB-first) into the
// running greater/equal state.
module one_bit_comparator (
    input  logic gin,
    input  logic ein,
    input  logic xin,
    input  logic yin,
    output logic gout,
    output logic eout
);

    assign gout = gin | (ein & xin & ~yin);
    assign eout = ein & ~(xin ^ yin);

endmodule

// File: rtl/serial_slt_unit.sv
// Bit-serial SLT/SLTU compare: walks the latched operands MSB-first through a
// one_bit_comparator and stops at the first differing bit.
//
// state   | meaning
// IDLE    | waiting for start; flags hold the last result
// RUN     | one operand bit compared per cycle
// DONE    | result valid, done pulses for this cycle
module serial_slt_unit
    import alu_cmp_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             is_signed,
    output logic             busy,
    output logic             done,
    output logic             lt,
    output logic             eq,
    output logic             gt
);

    localparam int IW = $clog2(WIDTH);
    localparam logic [IW-1:0] IDX_TOP = IW'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic             g_q, g_d, e_q, e_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [2:0]       res_q, res_d;
    logic             done_q, done_d;
    logic             gout, eout;

    one_bit_comparator u_cell (
        .gin  (g_q),
        .ein  (e_q),
        .xin  (a_q[idx_q]),
        .yin  (b_q[idx_q]),
        .gout (gout),
        .eout (eout)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        g_d     = g_q;
        e_d     = e_q;
        idx_d   = idx_q;
        res_d   = res_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    // Flipping both sign bits maps signed order onto unsigned order
                    a_d     = {a[WIDTH-1] ^ is_signed, a[WIDTH-2:0]};
                    b_d     = {b[WIDTH-1] ^ is_signed, b[WIDTH-2:0]};
                    g_d     = 1'b0;
                    e_d     = 1'b1;
                    idx_d   = IDX_TOP;
                    res_d   = 3'b000;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                g_d = gout;
                e_d = eout;
                if (!eout || idx_q == '0) begin
                    res_d[CMP_LT] = ~gout & ~eout;
                    res_d[CMP_EQ] = eout;
                    res_d[CMP_GT] = gout;
                    done_d        = 1'b1;
                    state_d       = ST_DONE;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            g_q     <= 1'b0;
            e_q     <= 1'b1;
            idx_q   <= IDX_TOP;
            res_q   <= 3'b000;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            g_q     <= g_d;
            e_q     <= e_d;
            idx_q   <= idx_d;
            res_q   <= res_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign done = done_q;
    assign lt   = res_q[CMP_LT];
    assign eq   = res_q[CMP_EQ];
    assign gt   = res_q[CMP_GT];

endmodule

// File: tb/tb_serial_slt_unit.sv
// Scoreboard bench for serial_slt_unit at WIDTH=32 and WIDTH=2: drivers push
// expected flags and done cycle, negedge monitors pop and compare on done.
module tb_serial_slt_unit;

    typedef struct {
        logic [2:0] flags;   // {lt, eq, gt}
        int         cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, start2 = 1'b0;
    logic [31:0] a = '0, b = '0;
    logic [1:0]  a2 = '0, b2 = '0;
    logic        is_signed = 1'b0, sgn2 = 1'b0;
    logic        busy, done, lt, eq, gt;
    logic        busy2, done2, lt2, eq2, gt2;

    exp_t q32[$];
    exp_t q2[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    logic prev_done = 1'b0, prev_done2 = 1'b0;

    serial_slt_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .is_signed(is_signed),
        .busy(busy), .done(done), .lt(lt), .eq(eq), .gt(gt)
    );

    serial_slt_unit #(.WIDTH(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .is_signed(sgn2),
        .busy(busy2), .done(done2), .lt(lt2), .eq(eq2), .gt(gt2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (done) begin
            check("done32_single", {31'd0, prev_done}, 0);
            if (q32.size() == 0) check("done32_unexpected", 1, 0);
            else begin
                e = q32.pop_front();
                check("flags32", {29'd0, lt, eq, gt}, {29'd0, e.flags});
                check("lat32", cyc, e.cyc);
            end
        end
        prev_done = done;
    end

    always @(negedge clk) begin
        exp_t e;
        if (done2) begin
            check("done2_single", {31'd0, prev_done2}, 0);
            if (q2.size() == 0) check("done2_unexpected", 1, 0);
            else begin
                e = q2.pop_front();
                check("flags2", {29'd0, lt2, eq2, gt2}, {29'd0, e.flags});
                check("lat2", cyc, e.cyc);
            end
        end
        prev_done2 = done2;
    end

    // lat = number of edges from the accepting edge to the end of the done cycle
    task automatic issue32(input logic [31:0] av, input logic [31:0] bv, input logic s,
                           input logic [2:0] fl, input int lat, input bit push);
        @(negedge clk);
        a = av; b = bv; is_signed = s; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (push) q32.push_back('{fl, cyc + lat - 1});
    endtask

    task automatic issue2(input logic [1:0] av, input logic [1:0] bv, input logic s,
                          input logic [2:0] fl, input int lat);
        @(negedge clk);
        a2 = av; b2 = bv; sgn2 = s; start2 = 1'b1;
        @(posedge clk);
        #1;
        start2 = 1'b0;
        q2.push_back('{fl, cyc + lat - 1});
    endtask

    task automatic wait_idle(input bit sel2);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!(sel2 ? busy2 : busy)) return;
        end
        check(sel2 ? "idle2_timeout" : "idle32_timeout", 1, 0);
    endtask

    task automatic busy_len(input string name);
        int n;
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy) break;
            n++;
        end
        check(name, n, 33);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset32_outputs", {27'd0, busy, done, lt, eq, gt}, 0);
        check("reset2_outputs", {27'd0, busy2, done2, lt2, eq2, gt2}, 0);
        rst = 1'b0;

        issue32(32'd5, 32'd9, 1'b0, 3'b100, 30, 1'b1);
        wait_idle(1'b0);
        issue32(32'hFFFF_FFFF, 32'd1, 1'b1, 3'b100, 2, 1'b1);
        wait_idle(1'b0);
        issue32(32'hFFFF_FFFF, 32'd1, 1'b0, 3'b001, 2, 1'b1);
        wait_idle(1'b0);
        issue32(32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1, 3'b010, 33, 1'b1);
        busy_len("busy_len_signed");
        wait_idle(1'b0);
        issue32(32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 3'b010, 33, 1'b1);
        busy_len("busy_len_unsigned");
        wait_idle(1'b0);

        // start held from the RUN cycle through DONE: only the first IDLE edge accepts it
        issue32(32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 3'b100, 2, 1'b1);
        a = 32'd3; b = 32'd3; is_signed = 1'b0; start = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #1;
        start = 1'b0;
        q32.push_back('{3'b010, cyc + 33 - 1});
        wait_idle(1'b0);

        issue32(32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 3'b010, 33, 1'b0);
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_outputs", {27'd0, busy, done, lt, eq, gt}, 0);
        repeat (40) @(negedge clk);
        check("abort_still_idle", {27'd0, busy, lt, eq, gt}, 0);
        issue32(32'd0, 32'd1, 1'b0, 3'b100, 33, 1'b1);
        wait_idle(1'b0);

        issue2(2'b10, 2'b01, 1'b1, 3'b100, 2);
        wait_idle(1'b1);
        issue2(2'b10, 2'b01, 1'b0, 3'b001, 2);
        wait_idle(1'b1);
        issue2(2'b11, 2'b11, 1'b1, 3'b010, 3);
        wait_idle(1'b1);
        issue2(2'b00, 2'b01, 1'b0, 3'b100, 3);
        wait_idle(1'b1);

        repeat (5) @(negedge clk);
        check("q32_drained", q32.size(), 0);
        check("q2_drained", q2.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
